// File: rtl/spi_master_periph.sv
// APB-attached single-channel 8-bit SPI master, MSB first, full duplex.
// One hardware chip select; CPOL/CPHA and the clock divider are set through registers.
module spi_master_periph (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n
);

    // state | meaning
    // IDLE  | cs_n high, sclk parked at CPOL
    // XFER  | cs_n low, 16 sclk edges being generated
    typedef enum logic {ST_IDLE, ST_XFER} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_en, r_cpol, r_cpha, r_done;
    logic [7:0]  r_div, r_div_lat, r_txd, r_rxd, r_shift, r_cnt;
    logic [3:0]  r_edge;
    logic        r_sclk, r_mosi, r_in;

    logic        w_acc, w_wr, w_rd, w_busy, w_tc, w_last, w_start, w_abort, w_done_set;
    logic [2:0]  w_off;
    logic        w_unused;

    assign w_acc      = PSEL & PENABLE;
    assign w_wr       = w_acc & PWRITE;
    assign w_rd       = w_acc & ~PWRITE;
    assign w_off      = PADDR[4:2];
    assign w_busy     = (r_state == ST_XFER);
    assign w_tc       = (r_cnt == r_div_lat);
    assign w_last     = w_tc & (r_edge == 4'd15);
    assign w_start    = w_wr & (w_off == 3'd2) & r_en & ~w_busy;
    assign w_abort    = w_busy & ~r_en;
    assign w_done_set = w_busy & ~w_abort & w_last;
    assign w_unused   = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:8]};

    assign PREADY = w_acc;
    assign cs_n   = ~w_busy;
    assign sclk   = w_busy ? r_sclk : r_cpol;
    assign mosi   = r_mosi;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_XFER;
            ST_XFER: if (w_abort || w_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        PRDATA = '0;
        if (w_rd) begin
            case (w_off)
                3'd0:    PRDATA[2:0] = {r_cpha, r_cpol, r_en};
                3'd1:    PRDATA[7:0] = r_div;
                3'd2:    PRDATA[7:0] = r_txd;
                3'd3:    PRDATA[1:0] = {r_done, w_busy};
                3'd4:    PRDATA[7:0] = r_rxd;
                default: PRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state   <= ST_IDLE;
            r_en      <= 1'b0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_done    <= 1'b0;
            r_div     <= '0;
            r_div_lat <= '0;
            r_txd     <= '0;
            r_rxd     <= '0;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_edge    <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_in      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_wr) begin
                case (w_off)
                    3'd0: begin
                        r_en <= PWDATA[0];
                        if (!w_busy) begin
                            r_cpol <= PWDATA[1];
                            r_cpha <= PWDATA[2];
                        end
                    end
                    3'd1:    r_div <= PWDATA[7:0];
                    3'd2:    r_txd <= PWDATA[7:0];
                    default: ;
                endcase
            end

            // completion beats a coincident W1C
            if (w_done_set)
                r_done <= 1'b1;
            else if (w_wr && (w_off == 3'd3) && PWDATA[1])
                r_done <= 1'b0;

            if (w_start) begin
                r_shift   <= PWDATA[7:0];
                r_mosi    <= PWDATA[7];
                r_cnt     <= '0;
                r_edge    <= '0;
                r_div_lat <= r_div;
                r_sclk    <= r_cpol;
            end else if (w_busy && !w_abort && w_tc) begin
                r_cnt  <= '0;
                r_sclk <= ~r_sclk;
                r_edge <= r_edge + 4'd1;
                // even counter value means this toggle is a leading edge
                if (!r_edge[0]) begin
                    if (!r_cpha) begin
                        r_in <= miso;
                    end else begin
                        r_mosi  <= r_shift[7];
                        r_shift <= {r_shift[6:0], 1'b0};
                    end
                end else begin
                    if (!r_cpha) begin
                        r_shift <= {r_shift[6:0], r_in};
                        r_mosi  <= r_shift[6];
                    end else begin
                        r_shift[0] <= miso;
                    end
                end
                if (w_last)
                    r_rxd <= r_cpha ? {r_shift[7:1], miso} : {r_shift[6:0], r_in};
            end else if (w_busy) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_periph.sv
// Directed bench for spi_master_periph: APB register access, SPI modes 0/3,
// busy rejection, DONE W1C race, abort and asynchronous reset.
module tb_spi_master_periph;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [31:0] PADDR, PWDATA;
    logic        PWRITE, PENABLE, PSEL;
    logic [31:0] PRDATA;
    logic        PREADY, sclk, mosi, cs_n;
    logic        miso;

    logic        loopback = 1'b0;
    logic        s_miso = 1'b0;
    logic        s_cpol = 1'b0, s_cpha = 1'b0;
    logic [7:0]  s_tx = 8'h00, s_sh = 8'h00, s_rx = 8'h00;

    int n_checks = 0, n_fails = 0;
    int cyc = 0, cs_low_cnt = 0, rise_cnt = 0, tog_cnt = 0;
    int tog1_cyc = 0, tog2_cyc = 0, csfall_cyc = 0;
    logic p_cs = 1'b1, p_sclk = 1'b0;

    assign miso = loopback ? mosi : s_miso;

    spi_master_periph dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA),
        .PREADY(PREADY), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 PCLK = ~PCLK;

    // SPI slave model and line monitor, sampled mid-cycle
    always @(negedge PCLK) begin
        cyc++;
        if (!cs_n) cs_low_cnt++;
        if (p_cs && !cs_n) begin
            csfall_cyc = cyc;
            s_sh = s_tx;
            s_rx = 8'h00;
            if (!s_cpha) begin
                s_miso = s_sh[7];
                s_sh = {s_sh[6:0], 1'b0};
            end
        end else if (!p_cs && (sclk != p_sclk)) begin
            tog_cnt++;
            if (tog_cnt == 1) tog1_cyc = cyc;
            if (tog_cnt == 2) tog2_cyc = cyc;
            if (sclk && !p_sclk) rise_cnt++;
            if ((sclk != s_cpol) ^ s_cpha) begin
                s_rx = {s_rx[6:0], mosi};
            end else begin
                s_miso = s_sh[7];
                s_sh = {s_sh[6:0], 1'b0};
            end
        end
        p_cs = cs_n;
        p_sclk = sclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic rdy);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1;
        d = PRDATA;
        rdy = PREADY;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic rdy;
        apb_rd(a, d, rdy);
        check(tag, d, exp);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] d;
        logic rdy;
        int n;
        n = 0;
        do begin
            apb_rd(32'h0C, d, rdy);
            n++;
        end while (d[0] && n < 500);
        check(tag, {31'd0, d[0]}, 32'd0);
    endtask

    task automatic clr_mon();
        cs_low_cnt = 0; rise_cnt = 0; tog_cnt = 0;
        tog1_cyc = 0; tog2_cyc = 0; csfall_cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        #1;
        check("rst_cs_n", {31'd0, cs_n}, 32'd1);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_pready", {31'd0, PREADY}, 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(posedge PCLK); #1;
        rd_check("rst_sr", 32'h0C, 32'h0);

        // mode 0 loopback, DIV=0
        loopback = 1'b1;
        apb_wr(32'h00, 32'h1);
        apb_wr(32'h04, 32'h0);
        clr_mon();
        apb_wr(32'h08, 32'hA5);
        check("m0_cs_low_after_start", {31'd0, cs_n}, 32'd0);
        wait_idle("m0_busy_clear");
        check("m0_cs_low_cycles", cs_low_cnt, 32'd16);
        check("m0_rising_edges", rise_cnt, 32'd8);
        rd_check("m0_rxd", 32'h10, 32'hA5);
        rd_check("m0_sr", 32'h0C, 32'h2);

        // mode 3 with slave, DIV=3
        loopback = 1'b0;
        s_cpol = 1'b1; s_cpha = 1'b1; s_tx = 8'h3C;
        apb_wr(32'h00, 32'h7);
        apb_wr(32'h04, 32'h3);
        check("m3_sclk_idle", {31'd0, sclk}, 32'd1);
        clr_mon();
        apb_wr(32'h08, 32'hC3);
        wait_idle("m3_busy_clear");
        check("m3_slave_rx", {24'd0, s_rx}, 32'hC3);
        rd_check("m3_rxd", 32'h10, 32'h3C);
        check("m3_cs_low_cycles", cs_low_cnt, 32'd64);
        check("m3_toggles", tog_cnt, 32'd16);
        check("m3_first_edge_delay", tog1_cyc - csfall_cyc, 32'd4);
        check("m3_half_period", tog2_cyc - tog1_cyc, 32'd4);
        check("m3_sclk_idle_after", {31'd0, sclk}, 32'd1);

        // busy rejection, mode 0, DIV=1
        s_cpol = 1'b0; s_cpha = 1'b0; s_tx = 8'h5A;
        apb_wr(32'h00, 32'h1);
        apb_wr(32'h04, 32'h1);
        clr_mon();
        apb_wr(32'h08, 32'h11);
        repeat (8) @(posedge PCLK);
        #1;
        apb_wr(32'h08, 32'h22);
        apb_wr(32'h00, 32'h3);
        rd_check("busy_cr_cpol_ignored", 32'h00, 32'h1);
        wait_idle("busy_busy_clear");
        check("busy_slave_rx", {24'd0, s_rx}, 32'h11);
        rd_check("busy_rxd", 32'h10, 32'h5A);
        rd_check("busy_txd_readback", 32'h08, 32'h22);
        repeat (20) @(posedge PCLK);
        #1;
        check("busy_no_second_xfer", tog_cnt, 32'd16);
        check("busy_cs_low_cycles", cs_low_cnt, 32'd32);
        check("busy_sclk_idle", {31'd0, sclk}, 32'd0);

        // DONE W1C, then W1C coincident with completion (DIV=0)
        apb_wr(32'h0C, 32'h2);
        rd_check("w1c_sr_cleared", 32'h0C, 32'h0);
        apb_wr(32'h04, 32'h0);
        apb_wr(32'h08, 32'h5A);
        repeat (14) @(posedge PCLK);
        #1;
        apb_wr(32'h0C, 32'h2);
        rd_check("w1c_race_set_wins", 32'h0C, 32'h2);
        rd_check("w1c_rxd", 32'h10, 32'h5A);

        // abort mid-transfer, DIV=1
        apb_wr(32'h0C, 32'h2);
        rd_check("abort_sr_pre", 32'h0C, 32'h0);
        apb_wr(32'h04, 32'h1);
        apb_wr(32'h08, 32'h77);
        repeat (6) @(posedge PCLK);
        #1;
        apb_wr(32'h00, 32'h0);
        @(posedge PCLK); #1;
        check("abort_cs_n", {31'd0, cs_n}, 32'd1);
        check("abort_sclk", {31'd0, sclk}, 32'd0);
        rd_check("abort_sr", 32'h0C, 32'h0);
        rd_check("abort_rxd_kept", 32'h10, 32'h5A);

        // asynchronous reset mid-transfer, CPOL=1
        apb_wr(32'h00, 32'h3);
        apb_wr(32'h04, 32'h2);
        apb_wr(32'h08, 32'h99);
        repeat (7) @(posedge PCLK);
        #2;
        check("prereset_cs_low", {31'd0, cs_n}, 32'd0);
        PRESET = 1'b1;
        #1;
        check("areset_cs_n", {31'd0, cs_n}, 32'd1);
        check("areset_sclk", {31'd0, sclk}, 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        rd_check("areset_cr", 32'h00, 32'h0);
        rd_check("areset_div", 32'h04, 32'h0);
        rd_check("areset_txd", 32'h08, 32'h0);
        rd_check("areset_sr", 32'h0C, 32'h0);
        rd_check("areset_rxd", 32'h10, 32'h0);
        begin
            logic [31:0] d;
            logic rdy;
            apb_wr(32'h14, 32'hFFFF_FFFF);
            apb_rd(32'h14, d, rdy);
            check("unmapped_prdata", d, 32'h0);
            check("unmapped_pready", {31'd0, rdy}, 32'd1);
            rd_check("unmapped_wr_ignored_cr", 32'h00, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
